// File: rtl/decode_stage_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | decode_stage_if : fetch, ID/EX slot and write-back bundle of decode    |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
interface decode_stage_if #(
  parameter int XLEN = 32
);
  logic            i_if_valid;
  logic            o_if_ready;
  logic [31:0]     i_if_instr;
  logic [XLEN-1:0] i_if_pc;

  logic            o_ex_valid;
  logic            i_ex_ready;
  logic [6:0]      o_ex_opcode;
  logic [2:0]      o_ex_funct3;
  logic [6:0]      o_ex_funct7;
  logic [XLEN-1:0] o_ex_imm;
  logic [XLEN-1:0] o_ex_pc;
  logic [XLEN-1:0] o_ex_rs1_rdata;
  logic [XLEN-1:0] o_ex_rs2_rdata;
  logic [4:0]      o_ex_rd_waddr;
  logic            o_ex_illegal;

  logic            i_flush;
  logic            i_wb_valid;
  logic [4:0]      i_wb_waddr;
  logic [XLEN-1:0] i_wb_wdata;

  logic [4:0]      dbg_rs1_raddr;
  logic [4:0]      dbg_rs2_raddr;
  logic [4:0]      dbg_rd_waddr;

  modport slave (
    input  i_if_valid, i_if_instr, i_if_pc, i_ex_ready, i_flush,
    input  i_wb_valid, i_wb_waddr, i_wb_wdata,
    output o_if_ready, o_ex_valid, o_ex_opcode, o_ex_funct3, o_ex_funct7,
    output o_ex_imm, o_ex_pc, o_ex_rs1_rdata, o_ex_rs2_rdata,
    output o_ex_rd_waddr, o_ex_illegal,
    output dbg_rs1_raddr, dbg_rs2_raddr, dbg_rd_waddr
  );

  modport master (
    output i_if_valid, i_if_instr, i_if_pc, i_ex_ready, i_flush,
    output i_wb_valid, i_wb_waddr, i_wb_wdata,
    input  o_if_ready, o_ex_valid, o_ex_opcode, o_ex_funct3, o_ex_funct7,
    input  o_ex_imm, o_ex_pc, o_ex_rs1_rdata, o_ex_rs2_rdata,
    input  o_ex_rd_waddr, o_ex_illegal,
    input  dbg_rs1_raddr, dbg_rs2_raddr, dbg_rd_waddr
  );
endinterface
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | decode_stage : RV32I/E decode, register file, load-use scoreboard, ID/EX |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module decode_stage #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic          clk,
  input  logic          rst,
  decode_stage_if.slave bus
);

  localparam int         c_AW     = $clog2(NREGS);
  localparam logic [5:0] c_NREGS  = 6'(NREGS);

  localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
  localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
  localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
  localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
  localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] c_OPC_OP     = 7'b0110011;
  localparam logic [6:0] c_OPC_MISC   = 7'b0001111;
  localparam logic [6:0] c_OPC_SYSTEM = 7'b1110011;

  // ---------------- field extraction ----------------
  logic [31:0] w_instr;
  logic [6:0]  w_opc;
  logic [4:0]  w_rd;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;

  assign w_instr = bus.i_if_instr;
  assign w_opc   = w_instr[6:0];
  assign w_rd    = w_instr[11:7];
  assign w_rs1   = w_instr[19:15];
  assign w_rs2   = w_instr[24:20];

  assign bus.dbg_rs1_raddr = w_rs1;
  assign bus.dbg_rs2_raddr = w_rs2;
  assign bus.dbg_rd_waddr  = w_rd;

  // ---------------- opcode class and immediate ----------------
  logic        w_known;
  logic        w_rs1_used;
  logic        w_rs2_used;
  logic        w_rd_used;
  logic [31:0] w_imm32;
  logic [XLEN-1:0] w_imm;

  always_comb begin
    w_known    = 1'b1;
    w_rs2_used = 1'b0;
    w_rd_used  = 1'b1;
    w_imm32    = '0;
    case (w_opc)
      c_OPC_LUI, c_OPC_AUIPC: w_imm32 = {w_instr[31:12], 12'b0};
      c_OPC_JAL: w_imm32 = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12],
                            w_instr[20], w_instr[30:21], 1'b0};
      c_OPC_JALR, c_OPC_LOAD, c_OPC_OPIMM, c_OPC_SYSTEM:
        w_imm32 = {{20{w_instr[31]}}, w_instr[31:20]};
      c_OPC_BRANCH: begin
        w_rd_used  = 1'b0;
        w_rs2_used = 1'b1;
        w_imm32    = {{19{w_instr[31]}}, w_instr[31], w_instr[7],
                      w_instr[30:25], w_instr[11:8], 1'b0};
      end
      c_OPC_STORE: begin
        w_rd_used  = 1'b0;
        w_rs2_used = 1'b1;
        w_imm32    = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
      end
      c_OPC_OP:   w_rs2_used = 1'b1;
      c_OPC_MISC: w_rs2_used = 1'b0;
      default:    w_known    = 1'b0;
    endcase
  end

  assign w_rs1_used = !((w_opc == c_OPC_LUI) || (w_opc == c_OPC_AUIPC) ||
                        (w_opc == c_OPC_JAL));
  assign w_imm      = XLEN'(signed'(w_imm32));

  // Indices at or above NREGS only matter for the RV32E-sized file.
  logic w_rs1_ok;
  logic w_rs2_ok;
  logic w_rd_ok;
  logic w_illegal;

  assign w_rs1_ok  = {1'b0, w_rs1} < c_NREGS;
  assign w_rs2_ok  = {1'b0, w_rs2} < c_NREGS;
  assign w_rd_ok   = {1'b0, w_rd}  < c_NREGS;
  assign w_illegal = !w_known || (w_rs1_used && !w_rs1_ok) ||
                     (w_rs2_used && !w_rs2_ok) || (w_rd_used && !w_rd_ok);

  // ---------------- register file ----------------
  logic [XLEN-1:0] rf_q [NREGS];
  logic            w_wb_we;
  logic [XLEN-1:0] w_rs1_rdata;
  logic [XLEN-1:0] w_rs2_rdata;

  assign w_wb_we = bus.i_wb_valid && (bus.i_wb_waddr != 5'd0) &&
                   ({1'b0, bus.i_wb_waddr} < c_NREGS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else if (w_wb_we) begin
      rf_q[bus.i_wb_waddr[c_AW-1:0]] <= bus.i_wb_wdata;
    end
  end

  // Same-cycle write-back is forwarded so a stalled consumer can leave on it.
  always_comb begin
    w_rs1_rdata = '0;
    if ((w_rs1 != 5'd0) && w_rs1_ok) begin
      if (w_wb_we && (bus.i_wb_waddr == w_rs1)) w_rs1_rdata = bus.i_wb_wdata;
      else                                      w_rs1_rdata = rf_q[w_rs1[c_AW-1:0]];
    end
  end

  always_comb begin
    w_rs2_rdata = '0;
    if ((w_rs2 != 5'd0) && w_rs2_ok) begin
      if (w_wb_we && (bus.i_wb_waddr == w_rs2)) w_rs2_rdata = bus.i_wb_wdata;
      else                                      w_rs2_rdata = rf_q[w_rs2[c_AW-1:0]];
    end
  end

  // ---------------- ID/EX slot state ----------------
  logic            ex_valid_q;
  logic [6:0]      ex_opcode_q;
  logic [2:0]      ex_funct3_q;
  logic [6:0]      ex_funct7_q;
  logic [XLEN-1:0] ex_imm_q;
  logic [XLEN-1:0] ex_pc_q;
  logic [XLEN-1:0] ex_rs1_q;
  logic [XLEN-1:0] ex_rs2_q;
  logic [4:0]      ex_rd_q;
  logic            ex_illegal_q;

  // ---------------- scoreboard and hazard ----------------
  logic [NREGS-1:0] pend_q;
  logic [NREGS-1:0] pend_d;
  logic             w_slot_load;
  logic             w_slot_rd_ok;
  logic             w_issue;
  logic             w_haz1;
  logic             w_haz2;
  logic             w_hazard;

  assign w_slot_load  = ex_valid_q && (ex_opcode_q == c_OPC_LOAD) && (ex_rd_q != 5'd0);
  assign w_slot_rd_ok = {1'b0, ex_rd_q} < c_NREGS;
  assign w_issue      = ex_valid_q && bus.i_ex_ready;

  assign w_haz1 = w_rs1_used && (
                    (w_rs1_ok && pend_q[w_rs1[c_AW-1:0]] &&
                     !(w_wb_we && (bus.i_wb_waddr == w_rs1))) ||
                    (w_slot_load && (ex_rd_q == w_rs1)));
  assign w_haz2 = w_rs2_used && (
                    (w_rs2_ok && pend_q[w_rs2[c_AW-1:0]] &&
                     !(w_wb_we && (bus.i_wb_waddr == w_rs2))) ||
                    (w_slot_load && (ex_rd_q == w_rs2)));
  assign w_hazard = w_haz1 || w_haz2;

  // Set is applied after clear so an issuing load wins over a same-index write-back.
  always_comb begin
    pend_d = pend_q;
    if (w_wb_we) pend_d[bus.i_wb_waddr[c_AW-1:0]] = 1'b0;
    if (w_issue && w_slot_load && w_slot_rd_ok) pend_d[ex_rd_q[c_AW-1:0]] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend_q <= '0;
    else     pend_q <= pend_d;
  end

  // ---------------- handshake ----------------
  logic w_advance;
  logic w_ready;
  logic w_accept;

  assign w_advance = !ex_valid_q || bus.i_ex_ready;
  assign w_ready   = w_advance && !w_hazard && !bus.i_flush;
  assign w_accept  = bus.i_if_valid && w_ready;

  assign bus.o_if_ready = w_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q   <= 1'b0;
      ex_opcode_q  <= '0;
      ex_funct3_q  <= '0;
      ex_funct7_q  <= '0;
      ex_imm_q     <= '0;
      ex_pc_q      <= '0;
      ex_rs1_q     <= '0;
      ex_rs2_q     <= '0;
      ex_rd_q      <= '0;
      ex_illegal_q <= 1'b0;
    end else if (bus.i_flush) begin
      ex_valid_q <= 1'b0;
    end else if (w_accept) begin
      ex_valid_q   <= 1'b1;
      ex_opcode_q  <= w_opc;
      ex_funct3_q  <= w_instr[14:12];
      ex_funct7_q  <= w_instr[31:25];
      ex_imm_q     <= w_imm;
      ex_pc_q      <= bus.i_if_pc;
      ex_rs1_q     <= w_rs1_rdata;
      ex_rs2_q     <= w_rs2_rdata;
      ex_rd_q      <= w_rd;
      ex_illegal_q <= w_illegal;
    end else if (w_advance) begin
      ex_valid_q <= 1'b0;
    end
  end

  assign bus.o_ex_valid     = ex_valid_q;
  assign bus.o_ex_opcode    = ex_opcode_q;
  assign bus.o_ex_funct3    = ex_funct3_q;
  assign bus.o_ex_funct7    = ex_funct7_q;
  assign bus.o_ex_imm       = ex_imm_q;
  assign bus.o_ex_pc        = ex_pc_q;
  assign bus.o_ex_rs1_rdata = ex_rs1_q;
  assign bus.o_ex_rs2_rdata = ex_rs2_q;
  assign bus.o_ex_rd_waddr  = ex_rd_q;
  assign bus.o_ex_illegal   = ex_illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_decode_stage : directed vectors for decode_stage, RV32I and RV32E   |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        ex_ready;
  logic        flush;
  logic        wb_valid;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  decode_stage_if #(.XLEN(32)) b32 ();
  decode_stage_if #(.XLEN(32)) b16 ();

  assign b32.i_if_valid = if_valid;
  assign b32.i_if_instr = if_instr;
  assign b32.i_if_pc    = if_pc;
  assign b32.i_ex_ready = ex_ready;
  assign b32.i_flush    = flush;
  assign b32.i_wb_valid = wb_valid;
  assign b32.i_wb_waddr = wb_waddr;
  assign b32.i_wb_wdata = wb_wdata;

  assign b16.i_if_valid = if_valid;
  assign b16.i_if_instr = if_instr;
  assign b16.i_if_pc    = if_pc;
  assign b16.i_ex_ready = ex_ready;
  assign b16.i_flush    = flush;
  assign b16.i_wb_valid = wb_valid;
  assign b16.i_wb_waddr = wb_waddr;
  assign b16.i_wb_wdata = wb_wdata;

  decode_stage #(.XLEN(32), .NREGS(32)) u_dut32 (.clk(clk), .rst(rst), .bus(b32.slave));
  decode_stage #(.XLEN(32), .NREGS(16)) u_dut16 (.clk(clk), .rst(rst), .bus(b16.slave));

  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic        ill32;
    logic        ill16;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] instr, input logic [31:0] pc);
    if_valid = 1'b1;
    if_instr = instr;
    if_pc    = pc;
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
    wb_valid = 1'b1;
    wb_waddr = a;
    wb_wdata = d;
    tick();
    wb_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // instr, imm, rs1 data, rs2 data, rd, illegal (32 regs), illegal (16 regs)
    vecs[0] = '{32'hFFF28313, 32'hFFFF_FFFF, 32'h42, 32'h0,  5'd6,  1'b0, 1'b0}; // addi x6,x5,-1
    vecs[1] = '{32'h12345537, 32'h1234_5000, 32'h0,  32'h0,  5'd10, 1'b0, 1'b0}; // lui x10
    vecs[2] = '{32'h0022A423, 32'h0000_0008, 32'h42, 32'h10, 5'd8,  1'b0, 1'b0}; // sw x2,8(x5)
    vecs[3] = '{32'hFE000EE3, 32'hFFFF_FFFC, 32'h0,  32'h0,  5'd29, 1'b0, 1'b0}; // beq -4
    vecs[4] = '{32'h001000EF, 32'h0000_0800, 32'h0,  32'h0,  5'd1,  1'b0, 1'b0}; // jal x1,+2048
    vecs[5] = '{32'hFFFFF197, 32'hFFFF_F000, 32'h0,  32'h0,  5'd3,  1'b0, 1'b0}; // auipc x3
    vecs[6] = '{32'h00028067, 32'h0000_0000, 32'h42, 32'h0,  5'd0,  1'b0, 1'b0}; // jalr x0,0(x5)
    vecs[7] = '{32'h0000007F, 32'h0000_0000, 32'h0,  32'h0,  5'd0,  1'b1, 1'b1}; // unknown opcode
    vecs[8] = '{32'h402284B3, 32'h0000_0000, 32'h42, 32'h10, 5'd9,  1'b0, 1'b0}; // sub x9,x5,x2
    vecs[9] = '{32'h002088B3, 32'h0000_0000, 32'h0,  32'h10, 5'd17, 1'b0, 1'b1}; // add x17,x1,x2

    rst = 1'b1; if_valid = 1'b0; if_instr = '0; if_pc = '0; ex_ready = 1'b1;
    flush = 1'b0; wb_valid = 1'b0; wb_waddr = '0; wb_wdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_valid",  32'(b32.o_ex_valid), 32'd0);
    chk("rst_imm",    b32.o_ex_imm, 32'd0);
    chk("rst_pc",     b32.o_ex_pc, 32'd0);
    chk("rst_rs1",    b32.o_ex_rs1_rdata, 32'd0);
    chk("rst_ready",  32'(b32.o_if_ready), 32'd1);
    chk("rst_ready16", 32'(b16.o_if_ready), 32'd1);

    wb_write(5'd5, 32'h42);
    wb_write(5'd2, 32'h10);

    // Table vectors, one per cycle, with execute always ready.
    for (int i = 0; i < 10; i++) begin
      offer(vecs[i].instr, 32'h100 + 32'(i * 4));
      #1;
      chk("vec_ready", 32'(b32.o_if_ready), 32'd1);
      if (i == 0) begin
        chk("dbg_rs1", 32'(b32.dbg_rs1_raddr), 32'd5);
        chk("dbg_rs2", 32'(b32.dbg_rs2_raddr), 32'd31);
        chk("dbg_rd",  32'(b32.dbg_rd_waddr), 32'd6);
      end
      tick();
      if_valid = 1'b0;
      chk("vec_valid",  32'(b32.o_ex_valid), 32'd1);
      chk("vec_imm",    b32.o_ex_imm, vecs[i].imm);
      chk("vec_rs1",    b32.o_ex_rs1_rdata, vecs[i].rs1);
      chk("vec_rs2",    b32.o_ex_rs2_rdata, vecs[i].rs2);
      chk("vec_rd",     32'(b32.o_ex_rd_waddr), 32'(vecs[i].rd));
      chk("vec_pc",     b32.o_ex_pc, 32'h100 + 32'(i * 4));
      chk("vec_ill32",  32'(b32.o_ex_illegal), 32'(vecs[i].ill32));
      chk("vec_ill16",  32'(b16.o_ex_illegal), 32'(vecs[i].ill16));
      chk("vec_imm16",  b16.o_ex_imm, vecs[i].imm);
      chk("vec_rs1_16", b16.o_ex_rs1_rdata, vecs[i].rs1);
      chk("vec_rs2_16", b16.o_ex_rs2_rdata, vecs[i].rs2);
      if (i == 8) begin
        chk("sub_funct7", 32'(b32.o_ex_funct7), 32'h20);
        chk("sub_funct3", 32'(b32.o_ex_funct3), 32'h0);
        chk("sub_opcode", 32'(b32.o_ex_opcode), 32'h33);
      end
    end

    // Write-to-read bypass: add x7,x1,x2 while x1 is written.
    offer(32'h002083B3, 32'h200);
    wb_valid = 1'b1; wb_waddr = 5'd1; wb_wdata = 32'h1234;
    tick();
    if_valid = 1'b0; wb_valid = 1'b0;
    chk("byp_rs1", b32.o_ex_rs1_rdata, 32'h1234);
    chk("byp_rs2", b32.o_ex_rs2_rdata, 32'h10);
    chk("byp_rs1_16", b16.o_ex_rs1_rdata, 32'h1234);

    // Load-use: lw x3,0(x0) then add x4,x3,x3.
    offer(32'h00002183, 32'h210);
    tick();
    offer(32'h00318233, 32'h214);
    #1;
    chk("lu_ready_slot", 32'(b32.o_if_ready), 32'd0);
    tick();
    chk("lu_bubble", 32'(b32.o_ex_valid), 32'd0);
    chk("lu_ready_pend1", 32'(b32.o_if_ready), 32'd0);
    tick();
    chk("lu_ready_pend2", 32'(b32.o_if_ready), 32'd0);
    chk("lu_ready_pend16", 32'(b16.o_if_ready), 32'd0);
    wb_valid = 1'b1; wb_waddr = 5'd3; wb_wdata = 32'hDEAD;
    #1;
    chk("lu_ready_wb", 32'(b32.o_if_ready), 32'd1);
    tick();
    wb_valid = 1'b0; if_valid = 1'b0;
    chk("lu_valid", 32'(b32.o_ex_valid), 32'd1);
    chk("lu_rs1", b32.o_ex_rs1_rdata, 32'hDEAD);
    chk("lu_rs2", b32.o_ex_rs2_rdata, 32'hDEAD);
    chk("lu_rd", 32'(b32.o_ex_rd_waddr), 32'd4);
    chk("lu_pc", b32.o_ex_pc, 32'h214);

    // Back-pressure: slot must hold for three cycles.
    ex_ready = 1'b0;
    offer(32'hFFF28313, 32'h300);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_ready", 32'(b32.o_if_ready), 32'd0);
      chk("stall_valid", 32'(b32.o_ex_valid), 32'd1);
      chk("stall_rs1", b32.o_ex_rs1_rdata, 32'hDEAD);
      chk("stall_pc", b32.o_ex_pc, 32'h214);
      tick();
    end
    ex_ready = 1'b1;
    #1;
    chk("release_ready", 32'(b32.o_if_ready), 32'd1);
    tick();
    if_valid = 1'b0;
    chk("release_valid", 32'(b32.o_ex_valid), 32'd1);
    chk("release_imm", b32.o_ex_imm, 32'hFFFF_FFFF);
    chk("release_rs1", b32.o_ex_rs1_rdata, 32'h42);
    chk("release_pc", b32.o_ex_pc, 32'h300);

    // Flush with a valid load in the slot: the issue still marks x3 pending.
    offer(32'h00002183, 32'h400);
    tick();
    offer(32'hFFF28313, 32'h404);
    flush = 1'b1;
    #1;
    chk("flush_ready", 32'(b32.o_if_ready), 32'd0);
    tick();
    flush = 1'b0;
    chk("flush_valid", 32'(b32.o_ex_valid), 32'd0);
    chk("flush_pc_kept", b32.o_ex_pc, 32'h400);
    offer(32'h00318233, 32'h408);
    #1;
    chk("flush_sb_kept", 32'(b32.o_if_ready), 32'd0);
    wb_valid = 1'b1; wb_waddr = 5'd3; wb_wdata = 32'hBEEF;
    #1;
    chk("flush_wb_ready", 32'(b32.o_if_ready), 32'd1);
    tick();
    wb_valid = 1'b0; if_valid = 1'b0;
    chk("flush_after_rs1", b32.o_ex_rs1_rdata, 32'hBEEF);
    chk("flush_after_pc", b32.o_ex_pc, 32'h408);

    // Reset while stalled with a valid slot and x3 pending.
    offer(32'h00002183, 32'h500);   // lw x3
    tick();
    offer(32'h00002403, 32'h504);   // lw x8, issues lw x3
    tick();
    ex_ready = 1'b0;
    offer(32'h00318233, 32'h508);   // add x4,x3,x3
    #1;
    chk("rs_stall_ready", 32'(b32.o_if_ready), 32'd0);
    chk("rs_stall_valid", 32'(b32.o_ex_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("rs_valid", 32'(b32.o_ex_valid), 32'd0);
    chk("rs_pc", b32.o_ex_pc, 32'd0);
    rst = 1'b0;
    ex_ready = 1'b1;
    #1;
    chk("rs_ready", 32'(b32.o_if_ready), 32'd1);
    chk("rs_ready16", 32'(b16.o_if_ready), 32'd1);
    tick();
    if_valid = 1'b0;
    chk("rs_rf_cleared", b32.o_ex_rs1_rdata, 32'd0);
    chk("rs_after_valid", 32'(b32.o_ex_valid), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
